m6502_cycle_sequencer: RTL and testbench
========================================

M6502_CYCLE_SEQUENCER -- requirements
Module: m6502_cycle_sequencer

Interface
REQ-001 SHALL have parameter RESET_STATE, default S_FETCH, meaning the state entered on reset.
REQ-002 SHALL have port i_clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_ready, input, 1 bit: bus RDY; low stalls read cycles.
REQ-005 SHALL have ports i_operation (Operation), i_addressingMode (AddressingMode), i_accessType (AccessType) and i_index (Index), all inputs from the opcode decoder, valid in S_DECODE.
REQ-006 SHALL have port i_pageCross, input, 1 bit: the datapath index-add carried into the high byte.
REQ-007 SHALL have ports i_branchTaken and i_branchPageCross, inputs, 1 bit each: branch outcome and whether the target crosses a page.
REQ-008 SHALL have port o_state, output, SeqState: the current micro-step, which the datapath uses as its mux select.
REQ-009 SHALL have ports o_busRead, o_busWrite and o_sync, outputs, 1 bit each: read strobe, write strobe, and opcode-fetch (SYNC) strobe.
REQ-010 SHALL have port o_cycle, output, 3 bits: cycle index within the instruction; 0 at fetch.
REQ-011 SHALL have port o_instrDone, output, 1 bit: a one-cycle pulse on the last cycle of each instruction.

Function
REQ-012 SHALL implement states S_FETCH, S_DECODE, S_OPLO, S_OPHI, S_PTRLO, S_PTRHI, S_FIX, S_READ, S_MODIFY, S_WRITE, S_BRTAKEN, S_BRFIX and S_STACK.
REQ-013 SHALL assert o_sync and o_busRead in S_FETCH; from S_FETCH it SHALL go to S_DECODE.
REQ-014 SHALL take each instruction's path from its addressing mode and access type, using these total cycle counts:
- Immediate and Implied (non-stack): 2.
- ZeroPage: 3; read-modify-write (RMW) 5.
- ZeroPageIndexed: 4; RMW 6.
- Absolute: 4; RMW 6; JMP 3.
- AbsoluteIndexed: read 4, or 5 if i_pageCross; write 5; RMW 7.
- IndexedIndirect: 6 for read and write.
- IndirectIndexed: read 5, or 6 if i_pageCross; write 6.
- AbsoluteIndirect: 5.
REQ-015 SHALL enter S_FIX for an indexed read only when i_pageCross=1, and always for indexed writes and RMW.
REQ-016 For RMW, SHALL sequence S_READ, then S_MODIFY (which writes back the unmodified value), then S_WRITE.
REQ-017 For Relative mode, SHALL take 2 cycles when not taken, 3 cycles (via S_BRTAKEN) when taken, and 4 cycles (via S_BRFIX) when taken and i_branchPageCross=1.
REQ-018 For stack operations, S_STACK SHALL load a down-counter so the totals are PHA/PHP 3, PLA/PLP 4, JSR/RTS/RTI 6 and BRK 7.
REQ-019 SHALL assert o_busWrite during the PHA/PHP push cycle, the JSR and BRK push cycles, S_MODIFY, and S_WRITE.
REQ-020 When i_ready=0 in a cycle with o_busRead=1, SHALL hold the state, o_cycle and the stack counter unchanged.
REQ-021 SHALL ignore i_ready=0 in write cycles.
REQ-022 SHALL pulse o_instrDone on the final cycle of each instruction, and the next state SHALL be S_FETCH.
REQ-023 SHALL make o_cycle increment each advancing cycle and saturate at 7.
REQ-024 SHALL treat an unrecognised mode/operation combination as Implied with 2 cycles.

Reset
REQ-025 When i_reset=1 at a clock edge, the next state SHALL be RESET_STATE, with o_cycle=0, the stack counter 0, o_busWrite=0 and o_instrDone=0; this applies mid-instruction and overrides i_ready.
REQ-026 In the first cycle after reset is released, SHALL assert o_sync=1 and o_busRead=1.

Configuration
REQ-027 With M6502_DUMMY_ACCESS_EN defined, SHALL assert o_busRead in S_FIX and S_BRFIX and o_busWrite in S_MODIFY, matching the real bus.
REQ-028 With M6502_DUMMY_ACCESS_EN undefined, SHALL deassert both strobes in those states while keeping the cycle counts in REQ-014 to REQ-018 unchanged.

Structure
REQ-029 The SeqState enum and the stack cycle-count constants SHALL live in package M6502Defs, alongside Operation, AddressingMode, AccessType and Index.
REQ-030 SHALL place the combinational stack-length lookup in sub-module m6502_stack_len, with Operation in and a 3-bit count out.

Verification
REQ-031 A bench SHALL check: LDA imm (A9), then LDA abs,X (BD) with i_pageCross=0, then BD with i_pageCross=1 -> o_instrDone after 2, 4 and 5 cycles; o_sync only on cycle 0.
REQ-032 A bench SHALL check: ASL abs,X (1E) -> 7 cycles, with o_busWrite high on cycles 5 and 6 when M6502_DUMMY_ACCESS_EN is defined and only on cycle 6 when it is undefined.
REQ-033 A bench SHALL check: BNE (D0) with taken=0, then taken=1 and cross=0, then taken=1 and cross=1 -> 2, 3 and 4 cycles.
REQ-034 A bench SHALL check: LDA (zp),Y (B1) with i_ready=0 for 3 cycles during S_PTRHI -> o_state held, total 8 cycles; STA abs (8D) with i_ready=0 at S_WRITE -> no stall, 4 cycles.
REQ-035 A bench SHALL check: BRK (00) -> 7 cycles with o_busWrite on cycles 2-4; JSR (20) -> 6 cycles.
REQ-036 A bench SHALL check: i_reset asserted at cycle 3 of INC abs (EE) -> next cycle S_FETCH, o_cycle=0, o_busWrite=0.

Source files
------------

// File: rtl/m6502_cycle_sequencer_pkg.sv
// Decoder-facing types, sequencer states and stack cycle counts for the 6502 cycle sequencer.
// Shared by the sequencer, its stack-length lookup and the bench.
package M6502Defs;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_OPLO, S_OPHI, S_PTRLO, S_PTRHI, S_FIX,
      S_READ, S_MODIFY, S_WRITE, S_BRTAKEN, S_BRFIX, S_STACK
   } SeqState;

   typedef enum logic [3:0] {
      OP_OTHER, OP_JMP, OP_PHA, OP_PHP, OP_PLA, OP_PLP, OP_JSR, OP_RTS, OP_RTI, OP_BRK
   } Operation;

   typedef enum logic [3:0] {
      AM_IMPLIED, AM_IMMEDIATE, AM_ZEROPAGE, AM_ZEROPAGE_IDX, AM_ABSOLUTE,
      AM_ABSOLUTE_IDX, AM_INDEXED_INDIRECT, AM_INDIRECT_INDEXED,
      AM_ABSOLUTE_INDIRECT, AM_RELATIVE
   } AddressingMode;

   typedef enum logic [1:0] {ACC_READ, ACC_WRITE, ACC_RMW} AccessType;

   typedef enum logic [1:0] {IDX_NONE, IDX_X, IDX_Y} Index;

   // Cycles spent in S_STACK; JSR and BRK then finish with operand/vector reads.
   localparam logic [2:0] STK_LEN_PUSH = 3'd1;
   localparam logic [2:0] STK_LEN_PULL = 3'd2;
   localparam logic [2:0] STK_LEN_JSR  = 3'd3;
   localparam logic [2:0] STK_LEN_RET  = 3'd4;
   localparam logic [2:0] STK_LEN_BRK  = 3'd3;

   function automatic logic is_stack_op(input Operation op);
      return (op == OP_PHA) || (op == OP_PHP) || (op == OP_PLA) || (op == OP_PLP) ||
             (op == OP_JSR) || (op == OP_RTS) || (op == OP_RTI) || (op == OP_BRK);
   endfunction

   function automatic SeqState mem_entry(input AccessType acc);
      return (acc == ACC_WRITE) ? S_WRITE : S_READ;
   endfunction

endpackage

// File: rtl/m6502_cycle_sequencer_stack_len.sv
// Combinational lookup of how many S_STACK cycles a stack operation spends.
// Non-stack operations return 0.
module m6502_stack_len
   import M6502Defs::*;
(
   input  Operation   i_operation,
   output logic [2:0] o_len
);

   always_comb begin
      o_len = 3'd0;
      case (i_operation)
         OP_PHA, OP_PHP: o_len = STK_LEN_PUSH;
         OP_PLA, OP_PLP: o_len = STK_LEN_PULL;
         OP_JSR:         o_len = STK_LEN_JSR;
         OP_RTS, OP_RTI: o_len = STK_LEN_RET;
         OP_BRK:         o_len = STK_LEN_BRK;
         default:        o_len = 3'd0;
      endcase
   end

endmodule

// File: rtl/m6502_cycle_sequencer.sv
// 6502 per-instruction cycle sequencer: walks micro-steps from decoder mode/access, RDY stalls read cycles only.
// Define M6502_DUMMY_ACCESS_EN to strobe the bus on dummy cycles (S_FIX, S_BRFIX read; S_MODIFY write).
module m6502_cycle_sequencer
   import M6502Defs::*;
#(
   parameter SeqState RESET_STATE = S_FETCH
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ready,
   input  Operation      i_operation,
   input  AddressingMode i_addressingMode,
   input  AccessType     i_accessType,
   input  Index          i_index,
   input  logic          i_pageCross,
   input  logic          i_branchTaken,
   input  logic          i_branchPageCross,
   output SeqState       o_state,
   output logic          o_busRead,
   output logic          o_busWrite,
   output logic          o_sync,
   output logic [2:0]    o_cycle,
   output logic          o_instrDone
);

   SeqState       state_q, state_d, nxt;
   logic [2:0]    cycle_q, cycle_d;
   logic [2:0]    stk_cnt_q, stk_cnt_d, stk_cnt_nxt;
   Operation      op_q, op_d;
   AddressingMode mode_q, mode_d;
   AccessType     acc_q, acc_d;
   logic [2:0]    stk_len;
   logic          bus_rd, bus_wr, stall, last, has_idx;

   m6502_stack_len u_stack_len (
      .i_operation (i_operation),
      .o_len       (stk_len)
   );

   always_comb begin
      bus_rd = 1'b0;
      bus_wr = 1'b0;
      case (state_q)
         S_FETCH, S_DECODE, S_OPLO, S_OPHI, S_PTRLO, S_PTRHI, S_READ, S_BRTAKEN: bus_rd = 1'b1;
         S_WRITE: bus_wr = 1'b1;
         S_STACK: begin
            // JSR spends its first stack cycle on an internal read before the two pushes.
            bus_wr = (op_q == OP_PHA) || (op_q == OP_PHP) || (op_q == OP_BRK) ||
                     ((op_q == OP_JSR) && (stk_cnt_q <= 3'd1));
            bus_rd = !bus_wr;
         end
`ifdef M6502_DUMMY_ACCESS_EN
         S_FIX, S_BRFIX: bus_rd = 1'b1;
         S_MODIFY:       bus_wr = 1'b1;
`endif
         default: ;
      endcase
   end

   assign stall = bus_rd && !i_ready;

   always_comb begin
      nxt         = S_FETCH;
      stk_cnt_nxt = stk_cnt_q;
      op_d        = op_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      has_idx     = (i_index != IDX_NONE);
      case (state_q)
         S_FETCH: nxt = S_DECODE;
         S_DECODE: begin
            op_d   = i_operation;
            mode_d = i_addressingMode;
            acc_d  = i_accessType;
            if (is_stack_op(i_operation)) begin
               nxt         = S_STACK;
               stk_cnt_nxt = stk_len - 3'd1;
            end else begin
               // Anything not matched here finishes as a 2-cycle implied instruction.
               case (i_addressingMode)
                  AM_ZEROPAGE:          nxt = mem_entry(i_accessType);
                  AM_ZEROPAGE_IDX,
                  AM_INDEXED_INDIRECT:  if (has_idx) nxt = S_FIX;
                  AM_ABSOLUTE,
                  AM_ABSOLUTE_INDIRECT: nxt = S_OPHI;
                  AM_ABSOLUTE_IDX:      if (has_idx) nxt = S_OPHI;
                  AM_INDIRECT_INDEXED:  if (has_idx) nxt = S_PTRLO;
                  AM_RELATIVE:          if (i_branchTaken) nxt = S_BRTAKEN;
                  default:              nxt = S_FETCH;
               endcase
            end
         end
         S_STACK: begin
            if (stk_cnt_q != 3'd0) begin
               nxt         = S_STACK;
               stk_cnt_nxt = stk_cnt_q - 3'd1;
            end else if (op_q == OP_JSR) begin
               nxt = S_OPHI;
            end else if (op_q == OP_BRK) begin
               nxt = S_OPLO;
            end
         end
         S_OPLO: nxt = S_OPHI;
         S_OPHI: begin
            if (!is_stack_op(op_q)) begin
               case (mode_q)
                  AM_ABSOLUTE:          if (op_q != OP_JMP) nxt = mem_entry(acc_q);
                  AM_ABSOLUTE_IDX:      nxt = ((acc_q != ACC_READ) || i_pageCross) ? S_FIX : S_READ;
                  AM_ABSOLUTE_INDIRECT: nxt = S_PTRLO;
                  default:              nxt = S_FETCH;
               endcase
            end
         end
         S_PTRLO: nxt = S_PTRHI;
         S_PTRHI: begin
            case (mode_q)
               AM_INDEXED_INDIRECT: nxt = mem_entry(acc_q);
               AM_INDIRECT_INDEXED: nxt = ((acc_q != ACC_READ) || i_pageCross) ? S_FIX : S_READ;
               default:             nxt = S_FETCH;
            endcase
         end
         S_FIX:     nxt = (mode_q == AM_INDEXED_INDIRECT) ? S_PTRLO : mem_entry(acc_q);
         S_READ:    if (acc_q == ACC_RMW) nxt = S_MODIFY;
         S_MODIFY:  nxt = S_WRITE;
         S_BRTAKEN: if (i_branchPageCross) nxt = S_BRFIX;
         default:   nxt = S_FETCH;
      endcase
      last = (nxt == S_FETCH);
   end

   always_comb begin
      if (stall) begin
         state_d   = state_q;
         cycle_d   = cycle_q;
         stk_cnt_d = stk_cnt_q;
      end else begin
         state_d   = nxt;
         cycle_d   = last ? 3'd0 : ((cycle_q == 3'd7) ? 3'd7 : cycle_q + 3'd1);
         stk_cnt_d = stk_cnt_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= RESET_STATE;
         cycle_q   <= 3'd0;
         stk_cnt_q <= 3'd0;
         op_q      <= OP_OTHER;
         mode_q    <= AM_IMPLIED;
         acc_q     <= ACC_READ;
      end else begin
         state_q   <= state_d;
         cycle_q   <= cycle_d;
         stk_cnt_q <= stk_cnt_d;
         op_q      <= op_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
      end
   end

   assign o_state     = state_q;
   assign o_busRead   = bus_rd;
   assign o_busWrite  = bus_wr;
   assign o_sync      = (state_q == S_FETCH);
   assign o_cycle     = cycle_q;
   assign o_instrDone = last && !stall;

endmodule

// File: tb/tb_m6502_cycle_sequencer.sv
// Bench for m6502_cycle_sequencer: directed instruction cases plus random instructions and RDY
// stalls, checked against a per-cycle bus-activity model of each instruction.
module tb_m6502_cycle_sequencer;
   import M6502Defs::*;

   logic          i_clk = 1'b0;
   logic          i_reset, i_ready, i_pageCross, i_branchTaken, i_branchPageCross;
   Operation      i_operation;
   AddressingMode i_addressingMode;
   AccessType     i_accessType;
   Index          i_index;
   SeqState       o_state;
   logic          o_busRead, o_busWrite, o_sync, o_instrDone;
   logic [2:0]    o_cycle;

   int total = 0;
   int bad   = 0;

   m6502_cycle_sequencer dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_ready           (i_ready),
      .i_operation       (i_operation),
      .i_addressingMode  (i_addressingMode),
      .i_accessType      (i_accessType),
      .i_index           (i_index),
      .i_pageCross       (i_pageCross),
      .i_branchTaken     (i_branchTaken),
      .i_branchPageCross (i_branchPageCross),
      .o_state           (o_state),
      .o_busRead         (o_busRead),
      .o_busWrite        (o_busWrite),
      .o_sync            (o_sync),
      .o_cycle           (o_cycle),
      .o_instrDone       (o_instrDone)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Bus activity per cycle of one instruction: R read, W write, N idle (dummy cycle without strobe).
   function automatic string seq_of(input Operation op, input AddressingMode am, input AccessType acc,
                                    input Index ix, input logic pc, input logic tk, input logic bx);
      string dr, dw, tail, xfix;
      logic  has_ix;
`ifdef M6502_DUMMY_ACCESS_EN
      dr = "R";
      dw = "W";
`else
      dr = "N";
      dw = "N";
`endif
      if (acc == ACC_WRITE)    tail = "W";
      else if (acc == ACC_RMW) tail = {"R", dw, "W"};
      else                     tail = "R";
      if ((acc != ACC_READ) || pc) xfix = dr;
      else                         xfix = "";
      has_ix = (ix != IDX_NONE);
      case (op)
         OP_PHA, OP_PHP: return "RRW";
         OP_PLA, OP_PLP: return "RRRR";
         OP_JSR:         return "RRRWWR";
         OP_RTS, OP_RTI: return "RRRRRR";
         OP_BRK:         return "RRWWWRR";
         default: ;
      endcase
      case (am)
         AM_ZEROPAGE:          return {"RR", tail};
         AM_ZEROPAGE_IDX:      if (has_ix) return {"RR", dr, tail};
         AM_ABSOLUTE: begin
            if (op == OP_JMP) return "RRR";
            return {"RRR", tail};
         end
         AM_ABSOLUTE_IDX:      if (has_ix) return {"RRR", xfix, tail};
         AM_INDEXED_INDIRECT:  if (has_ix) return {"RR", dr, "RR", tail};
         AM_INDIRECT_INDEXED:  if (has_ix) return {"RRRR", xfix, tail};
         AM_ABSOLUTE_INDIRECT: return "RRRRR";
         AM_RELATIVE: begin
            if (!tk) return "RR";
            if (bx)  return {"RRR", dr};
            return "RRR";
         end
         default: ;
      endcase
      return "RR";
   endfunction

   // Runs one instruction starting in its fetch cycle; RDY is held low for stall_len cycles
   // at cycle index stall_at, or randomly when rnd_rdy is set.
   task automatic run_instr(input string tag, input Operation op, input AddressingMode am,
                            input AccessType acc, input Index ix, input logic pc, input logic tk,
                            input logic bx, input int stall_at, input int stall_len,
                            input SeqState stall_st, input int exp_total, input bit rnd_rdy);
      string s;
      int    k, cycles, used, nstall, done_at;
      logic  rdy, stall_now, busy;
      byte   kd;
      s       = seq_of(op, am, acc, ix, pc, tk, bx);
      k       = 0;
      cycles  = 0;
      used    = 0;
      nstall  = 0;
      done_at = -1;
      busy    = 1'b1;
      while (busy) begin
         @(negedge i_clk);
         i_operation       = op;
         i_addressingMode  = am;
         i_accessType      = acc;
         i_index           = ix;
         i_pageCross       = pc;
         i_branchTaken     = tk;
         i_branchPageCross = bx;
         if ((k == stall_at) && (used < stall_len)) begin
            rdy = 1'b0;
            used++;
         end else if (rnd_rdy) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            rdy = 1'b1;
         end
         i_ready = rdy;
         #1;
         kd        = s.getc(k);
         stall_now = (kd == "R") && !rdy;
         cycles++;
         if ((k == stall_at) && !rdy)
            check_val($sformatf("%s c%0d state", tag, k), o_state, stall_st);
         check_val($sformatf("%s c%0d cycle", tag, k), o_cycle, k);
         check_val($sformatf("%s c%0d sync", tag, k), o_sync, k == 0);
         check_val($sformatf("%s c%0d rd", tag, k), o_busRead, kd == "R");
         check_val($sformatf("%s c%0d wr", tag, k), o_busWrite, kd == "W");
         check_val($sformatf("%s c%0d done", tag, k), o_instrDone, (k == s.len() - 1) && !stall_now);
         if (o_instrDone === 1'b1 && done_at < 0) done_at = cycles;
         if (stall_now) begin
            nstall++;
         end else begin
            if (k == s.len() - 1) busy = 1'b0;
            k++;
         end
         if (cycles > 200) begin
            check_val({tag, " timeout"}, 0, 1);
            busy = 1'b0;
         end
      end
      if (exp_total > 0) check_val({tag, " total"}, done_at, exp_total);
      else               check_val({tag, " total"}, done_at, s.len() + nstall);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      i_reset           = 1'b1;
      i_ready           = 1'b1;
      i_operation       = OP_OTHER;
      i_addressingMode  = AM_IMPLIED;
      i_accessType      = ACC_READ;
      i_index           = IDX_NONE;
      i_pageCross       = 1'b0;
      i_branchTaken     = 1'b0;
      i_branchPageCross = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check_val("reset state", o_state, S_FETCH);
      check_val("reset cycle", o_cycle, 0);
      check_val("reset wr", o_busWrite, 0);
      check_val("reset done", o_instrDone, 0);
      i_reset = 1'b0;

      run_instr("lda_imm",     OP_OTHER, AM_IMMEDIATE,    ACC_READ, IDX_NONE, 0, 0, 0, -1, 0, S_FETCH, 2, 0);
      run_instr("lda_absx_nc", OP_OTHER, AM_ABSOLUTE_IDX, ACC_READ, IDX_X,    0, 0, 0, -1, 0, S_FETCH, 4, 0);
      run_instr("lda_absx_pc", OP_OTHER, AM_ABSOLUTE_IDX, ACC_READ, IDX_X,    1, 0, 0, -1, 0, S_FETCH, 5, 0);
      run_instr("asl_absx",    OP_OTHER, AM_ABSOLUTE_IDX, ACC_RMW,  IDX_X,    0, 0, 0, -1, 0, S_FETCH, 7, 0);
      run_instr("bne_nt",      OP_OTHER, AM_RELATIVE,     ACC_READ, IDX_NONE, 0, 0, 0, -1, 0, S_FETCH, 2, 0);
      run_instr("bne_t",       OP_OTHER, AM_RELATIVE,     ACC_READ, IDX_NONE, 0, 1, 0, -1, 0, S_FETCH, 3, 0);
      run_instr("bne_tx",      OP_OTHER, AM_RELATIVE,     ACC_READ, IDX_NONE, 0, 1, 1, -1, 0, S_FETCH, 4, 0);
      run_instr("lda_indy",    OP_OTHER, AM_INDIRECT_INDEXED, ACC_READ, IDX_Y, 0, 0, 0, 3, 3, S_PTRHI, 8, 0);
      run_instr("sta_abs",     OP_OTHER, AM_ABSOLUTE,     ACC_WRITE, IDX_NONE, 0, 0, 0, 3, 1, S_WRITE, 4, 0);
      run_instr("brk",         OP_BRK,   AM_IMPLIED,      ACC_READ, IDX_NONE, 0, 0, 0, -1, 0, S_FETCH, 7, 0);
      run_instr("jsr",         OP_JSR,   AM_ABSOLUTE,     ACC_READ, IDX_NONE, 0, 0, 0, -1, 0, S_FETCH, 6, 0);

      // INC abs interrupted by reset during its read cycle.
      i_operation      = OP_OTHER;
      i_addressingMode = AM_ABSOLUTE;
      i_accessType     = ACC_RMW;
      i_index          = IDX_NONE;
      i_ready          = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         #1;
         check_val($sformatf("inc_abs c%0d cycle", c), o_cycle, c);
      end
      i_reset = 1'b1;
      i_ready = 1'b0;
      @(posedge i_clk);
      #1;
      check_val("inc_rst state", o_state, S_FETCH);
      check_val("inc_rst cycle", o_cycle, 0);
      check_val("inc_rst wr", o_busWrite, 0);
      check_val("inc_rst done", o_instrDone, 0);
      i_reset = 1'b0;
      i_ready = 1'b1;
      run_instr("post_rst", OP_OTHER, AM_IMMEDIATE, ACC_READ, IDX_NONE, 0, 0, 0, -1, 0, S_FETCH, 2, 0);

      for (int n = 0; n < 300; n++) begin
         Operation      op;
         AddressingMode am;
         int            r;
         r = $urandom_range(0, 9);
         if (r < 2)       op = Operation'($urandom_range(2, 9));
         else if (r == 2) op = OP_JMP;
         else             op = OP_OTHER;
         am = AddressingMode'($urandom_range(0, 9));
         run_instr($sformatf("rnd%0d", n), op, am, AccessType'($urandom_range(0, 2)),
                   Index'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, S_FETCH, 0, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
